// File: rtl/register_file_onehot.sv
// ---------------------------------------------------------------------------
// register_file_onehot
//
// MIPS multicycle register file: 32 x N_BITS general-purpose registers with a
// one-hot write select and two addressed read ports whose data is captured
// every cycle into the A/B operand registers.
//
// Ports:
//   i_clk           rising-edge clock
//   i_reset         synchronous, active-high reset
//   i_reg_write     write strobe from the control unit
//   i_write_enable  one-hot register select from the write-register decoder
//   i_write_data    data to write
//   i_read_reg1     rs address
//   i_read_reg2     rt address
//   o_read_data1    registered rs value (A register)
//   o_read_data2    registered rt value (B register)
//   o_onehot_error  sticky: write strobe seen with an invalid select vector
//
// Register 0 reads as zero.  A write to it through a valid vector is
// silently dropped.  Register 29 ($sp) resets to SP_INIT.
// A valid write whose target matches a read address is forwarded to that
// read port on the same edge, so the A/B registers are never stale.
// ---------------------------------------------------------------------------
module register_file_onehot #(
    parameter int                N_BITS  = 32,
    parameter logic [N_BITS-1:0] SP_INIT = N_BITS'(32'h7FFF_EFFC)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_reg_write,
    input  logic [31:0]       i_write_enable,
    input  logic [N_BITS-1:0] i_write_data,
    input  logic [4:0]        i_read_reg1,
    input  logic [4:0]        i_read_reg2,
    output logic [N_BITS-1:0] o_read_data1,
    output logic [N_BITS-1:0] o_read_data2,
    output logic              o_onehot_error
);

    localparam int N_REGS = 32;
    localparam int SP_IDX = 29;

    // -----------------------------------------------------------------------
    // Storage and output registers
    // -----------------------------------------------------------------------
    logic [N_BITS-1:0] r_regs [N_REGS];
    logic [N_BITS-1:0] r_read_data1;
    logic [N_BITS-1:0] r_read_data2;
    logic              r_onehot_error;

    // -----------------------------------------------------------------------
    // Write-vector qualification
    // -----------------------------------------------------------------------
    logic              w_vec_nonzero;
    logic              w_vec_single;
    logic              w_vec_valid;
    logic              w_do_write;
    logic              w_write_err;
    logic              w_hit1;
    logic              w_hit2;
    logic [N_BITS-1:0] w_next_read1;
    logic [N_BITS-1:0] w_next_read2;

    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves
    // nothing behind.  Cheaper than a full population count.
    assign w_vec_nonzero = |i_write_enable;
    assign w_vec_single  = ((i_write_enable & (i_write_enable - 32'd1)) == 32'd0);
    assign w_vec_valid   = w_vec_nonzero & w_vec_single;

    // A valid vector selecting register 0 is legal but writes nothing.
    assign w_do_write    = i_reg_write & w_vec_valid & ~i_write_enable[0];
    assign w_write_err   = i_reg_write & ~w_vec_valid;

    // Because the vector is one-hot when w_do_write is high, testing the
    // enable bit at the read address is the same as comparing the decoded
    // write index against that address.  Bit 0 is excluded by w_do_write.
    assign w_hit1 = w_do_write & i_write_enable[i_read_reg1];
    assign w_hit2 = w_do_write & i_write_enable[i_read_reg2];

    // -----------------------------------------------------------------------
    // Read-port value selection (zero register, write-first bypass, array)
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_read1 = '0;
        if (i_read_reg1 == 5'd0) begin
            w_next_read1 = '0;
        end else if (w_hit1) begin
            w_next_read1 = i_write_data;
        end else begin
            w_next_read1 = r_regs[i_read_reg1];
        end
    end

    always_comb begin
        w_next_read2 = '0;
        if (i_read_reg2 == 5'd0) begin
            w_next_read2 = '0;
        end else if (w_hit2) begin
            w_next_read2 = i_write_data;
        end else begin
            w_next_read2 = r_regs[i_read_reg2];
        end
    end

    // -----------------------------------------------------------------------
    // Register array
    // -----------------------------------------------------------------------
    // NOTE: this array is flops, not a RAM macro, so resetting every entry is
    // legal and required ($sp must come out of reset holding SP_INIT).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            // Entry 0 is never written, so it holds its reset value of zero.
            for (int i = 1; i < N_REGS; i++) begin
                if (w_do_write && i_write_enable[i]) begin
                    r_regs[i] <= i_write_data;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // A/B operand capture and sticky error flag
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would leak ordering between
    // processes into the captured data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_read_data1   <= '0;
            r_read_data2   <= '0;
            r_onehot_error <= 1'b0;
        end else begin
            r_read_data1 <= w_next_read1;
            r_read_data2 <= w_next_read2;
            if (w_write_err) begin
                r_onehot_error <= 1'b1;
            end
        end
    end

    assign o_read_data1   = r_read_data1;
    assign o_read_data2   = r_read_data2;
    assign o_onehot_error = r_onehot_error;

endmodule
